// File: rtl/sweep_pkg.sv
// Shared types and constants for the divider sweep controller.
package sweep_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DWELL,
        S_STEP,
        S_DONE
    } state_t;

    localparam logic [1:0] MODE_ONESHOT  = 2'b00;
    localparam logic [1:0] MODE_REPEAT   = 2'b01;
    localparam logic [1:0] MODE_TRIANGLE = 2'b10;

    // The unused encoding 11 behaves as one-shot.
    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        return (m == 2'b11) ? MODE_ONESHOT : m;
    endfunction

endpackage

// File: rtl/sweep_next.sv
// Combinational next-value calculator for one sweep step, using one extra bit
// so that stepping past either end clips instead of wrapping.
module sweep_next
    import sweep_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_cur,
    input  logic [WIDTH-1:0] i_step,
    input  logic [WIDTH-1:0] i_lo,
    input  logic [WIDTH-1:0] i_hi,
    input  logic             i_dir_up,
    input  logic [1:0]       i_mode,
    output logic [WIDTH-1:0] o_next,
    output logic             o_at_end,
    output logic             o_dir_next
);

    logic [WIDTH:0]   w_up_sum;
    logic [WIDTH:0]   w_dn_diff;
    logic [WIDTH-1:0] w_up_clip;
    logic [WIDTH-1:0] w_dn_clip;

    always_comb begin
        w_up_sum   = {1'b0, i_cur} + {1'b0, i_step};
        w_dn_diff  = {1'b0, i_cur} - {1'b0, i_step};
        w_up_clip  = (w_up_sum > {1'b0, i_hi}) ? i_hi : w_up_sum[WIDTH-1:0];
        w_dn_clip  = (w_dn_diff[WIDTH] || (w_dn_diff[WIDTH-1:0] < i_lo)) ? i_lo
                                                                         : w_dn_diff[WIDTH-1:0];
        o_at_end   = i_dir_up ? (i_cur == i_hi) : (i_cur == i_lo);
        o_next     = i_dir_up ? w_up_clip : w_dn_clip;
        o_dir_next = i_dir_up;
        if (o_at_end) begin
            case (i_mode)
                // Direction never changes in repeat mode, so it tells us where the sweep began.
                MODE_REPEAT: o_next = i_dir_up ? i_lo : i_hi;
                MODE_TRIANGLE: begin
                    o_next     = i_dir_up ? w_dn_clip : w_up_clip;
                    o_dir_next = ~i_dir_up;
                end
                default: o_next = i_cur;
            endcase
        end
    end

endmodule

// File: rtl/divider_sweep_ctrl.sv
// Sweep controller: steps the clock divider load value between two endpoints,
// holding each value for a programmed number of divided-clock rising edges.
module divider_sweep_ctrl
    import sweep_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [WIDTH-1:0]   cfg_start,
    input  logic [WIDTH-1:0]   cfg_stop,
    input  logic [WIDTH-1:0]   cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [1:0]         cfg_mode,
    input  logic               start,
    input  logic               abort,
    input  logic               clk_div,
    output logic [WIDTH-1:0]   par_load,
    output logic               ld,
    output logic               busy,
    output logic               done
);

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_start;
    logic [WIDTH-1:0]   r_stop;
    logic [WIDTH-1:0]   r_step;
    logic [DWELL_W-1:0] r_dwell;
    logic [1:0]         r_mode;
    logic               r_cfg_loaded;
    logic [WIDTH-1:0]   r_cur;
    logic               r_dir_up;
    logic [WIDTH-1:0]   r_par_load;
    logic [DWELL_W-1:0] r_dwell_cnt;
    logic               r_div_prev;
    logic               r_div_rise;

    logic               w_cfg_hs;
    logic               w_launch;
    logic [WIDTH-1:0]   w_eff_start;
    logic [WIDTH-1:0]   w_eff_stop;
    logic [WIDTH-1:0]   w_lo;
    logic [WIDTH-1:0]   w_hi;
    logic [WIDTH-1:0]   w_next;
    logic               w_at_end;
    logic               w_dir_next;
    logic               w_dwell_last;
    logic               w_reload;

    assign w_cfg_hs     = cfg_valid && (r_state == S_IDLE) && !abort;
    // A config offered in the same cycle as start is used for that launch.
    assign w_launch     = (r_state == S_IDLE) && start && !abort && (r_cfg_loaded || w_cfg_hs);
    assign w_eff_start  = w_cfg_hs ? cfg_start : r_start;
    assign w_eff_stop   = w_cfg_hs ? cfg_stop  : r_stop;
    assign w_lo         = (r_start <= r_stop) ? r_start : r_stop;
    assign w_hi         = (r_start <= r_stop) ? r_stop  : r_start;
    assign w_dwell_last = r_div_rise && (r_dwell_cnt == DWELL_W'(1));
    assign w_reload     = (r_state == S_STEP) && !(w_at_end && (r_mode == MODE_ONESHOT));

    sweep_next #(.WIDTH(WIDTH)) u_next (
        .i_cur      (r_cur),
        .i_step     (r_step),
        .i_lo       (w_lo),
        .i_hi       (w_hi),
        .i_dir_up   (r_dir_up),
        .i_mode     (r_mode),
        .o_next     (w_next),
        .o_at_end   (w_at_end),
        .o_dir_next (w_dir_next)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_launch) w_state_next = S_LOAD;
            S_LOAD:  w_state_next = S_DWELL;
            S_DWELL: if (w_dwell_last) w_state_next = S_STEP;
            S_STEP:  w_state_next = w_reload ? S_LOAD : S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (abort) w_state_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_start      <= '0;
            r_stop       <= '0;
            r_step       <= WIDTH'(1);
            r_dwell      <= DWELL_W'(1);
            r_mode       <= MODE_ONESHOT;
            r_cfg_loaded <= 1'b0;
            r_cur        <= '0;
            r_dir_up     <= 1'b1;
            r_par_load   <= '0;
            r_dwell_cnt  <= '0;
            r_div_prev   <= 1'b0;
            r_div_rise   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_div_prev <= clk_div;
            // Edges outside DWELL are dropped so they never count toward a dwell.
            r_div_rise <= (r_state == S_DWELL) && clk_div && !r_div_prev;
            if (w_cfg_hs) begin
                r_start      <= cfg_start;
                r_stop       <= cfg_stop;
                r_step       <= (cfg_step == '0) ? WIDTH'(1) : cfg_step;
                r_dwell      <= (cfg_dwell == '0) ? DWELL_W'(1) : cfg_dwell;
                r_mode       <= norm_mode(cfg_mode);
                r_cfg_loaded <= 1'b1;
            end
            if (w_launch) begin
                r_cur      <= w_eff_start;
                r_par_load <= w_eff_start;
                r_dir_up   <= (w_eff_start <= w_eff_stop);
            end
            if (r_state == S_LOAD) begin
                r_dwell_cnt <= r_dwell;
            end else if ((r_state == S_DWELL) && r_div_rise) begin
                r_dwell_cnt <= r_dwell_cnt - DWELL_W'(1);
            end
            if (w_reload && !abort) begin
                r_cur      <= w_next;
                r_par_load <= w_next;
                r_dir_up   <= w_dir_next;
            end
        end
    end

    assign par_load  = r_par_load;
    assign ld        = (r_state == S_LOAD);
    assign busy      = (r_state == S_LOAD) || (r_state == S_DWELL) || (r_state == S_STEP);
    assign done      = (r_state == S_DONE);
    assign cfg_ready = (r_state == S_IDLE);

endmodule

// File: tb/tb_divider_sweep_ctrl.sv
// Scoreboard bench for divider_sweep_ctrl: stimulus queues expected load/done
// events, a negedge monitor pops and compares them as the DUT produces them.
module tb_divider_sweep_ctrl;

    localparam int WIDTH   = 8;
    localparam int DWELL_W = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [WIDTH-1:0]   cfg_start;
    logic [WIDTH-1:0]   cfg_stop;
    logic [WIDTH-1:0]   cfg_step;
    logic [DWELL_W-1:0] cfg_dwell;
    logic [1:0]         cfg_mode;
    logic               start;
    logic               abort;
    logic               clk_div;
    logic [WIDTH-1:0]   par_load;
    logic               ld;
    logic               busy;
    logic               done;

    divider_sweep_ctrl #(.WIDTH(WIDTH), .DWELL_W(DWELL_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_start (cfg_start),
        .cfg_stop  (cfg_stop),
        .cfg_step  (cfg_step),
        .cfg_dwell (cfg_dwell),
        .cfg_mode  (cfg_mode),
        .start     (start),
        .abort     (abort),
        .clk_div   (clk_div),
        .par_load  (par_load),
        .ld        (ld),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_done;
        logic [7:0] val;
        int         edges;   // divided-clock rises since the previous event, -1 = don't care
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   tests = 0;
    int   fails = 0;
    int   ld_seen = 0;
    int   done_seen = 0;
    int   cyc = 0;
    int   last_ld_cyc = 0;
    int   rise_cnt = 0;
    int   div_ph = 0;
    logic prev_div = 1'b0;
    logic rise_now;

    // Divided clock: period 8 system clocks, 50% duty.
    initial begin
        clk_div = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            div_ph  = (div_ph + 1) % 8;
            clk_div = (div_ph < 4);
        end
    end

    // Monitor
    always @(negedge clk) begin
        cyc++;
        rise_now = clk_div && !prev_div;
        prev_div = clk_div;
        if (ld || done) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_event: cyc=%0d ld=%0d done=%0d par_load=%0d, required no event",
                         cyc, ld, done, par_load);
            end else begin
                e = exp_q.pop_front();
                tests++;
                if ((e.is_done != done) || (!done && (par_load != e.val))) begin
                    fails++;
                    $display("FAIL event: cyc=%0d got done=%0d par_load=%0d, required done=%0d par_load=%0d",
                             cyc, done, par_load, e.is_done, e.val);
                end
                if (e.edges >= 0) begin
                    tests++;
                    if (rise_cnt != e.edges) begin
                        fails++;
                        $display("FAIL dwell_edges: cyc=%0d got %0d rises, required %0d",
                                 cyc, rise_cnt, e.edges);
                    end
                end
            end
            if (ld) begin
                if (ld_seen > 0) begin
                    tests++;
                    if (cyc - last_ld_cyc < 3) begin
                        fails++;
                        $display("FAIL ld_spacing: got %0d cycles, required >= 3", cyc - last_ld_cyc);
                    end
                end
                last_ld_cyc = cyc;
                ld_seen++;
            end
            if (done) begin
                done_seen++;
                tests++;
                if (busy !== 1'b0) begin
                    fails++;
                    $display("FAIL busy_with_done: got %0d required 0", busy);
                end
            end
            rise_cnt = 0;
        end else if (rise_now) begin
            rise_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input bit is_done, input logic [7:0] val, input int edges);
        exp_t x;
        x.is_done = is_done;
        x.val     = val;
        x.edges   = edges;
        exp_q.push_back(x);
    endtask

    task automatic do_cfg(input logic [7:0] s, input logic [7:0] p, input logic [7:0] st,
                          input logic [7:0] dw, input logic [1:0] m);
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_start = s;
        cfg_stop  = p;
        cfg_step  = st;
        cfg_dwell = dw;
        cfg_mode  = m;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_abort();
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    int ld_mark;
    int done_mark;

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_start = '0; cfg_stop = '0; cfg_step = '0;
        cfg_dwell = '0; cfg_mode = '0; start = 1'b0; abort = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(5);
        check("reset_ld", 32'(ld), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_cfg_ready", 32'(cfg_ready), 1);
        check("reset_par_load", 32'(par_load), 0);

        // Start with no config loaded is ignored.
        do_start();
        tick(10);
        check("no_cfg_ld", 32'(ld_seen), 0);
        check("no_cfg_busy", 32'(busy), 0);

        // One-shot 10..40 step 10, dwell 2.
        do_cfg(8'd10, 8'd40, 8'd10, 8'd2, 2'b00);
        push(0, 8'd10, -1); push(0, 8'd20, 2); push(0, 8'd30, 2); push(0, 8'd40, 2); push(1, 8'd0, 2);
        do_start();
        check("ld_latency", 32'(ld), 1);
        check("first_par_load", 32'(par_load), 10);
        wait_drain("oneshot_drain", 300);
        tick(2);
        check("oneshot_done_count", 32'(done_seen), 1);
        check("oneshot_idle_busy", 32'(busy), 0);
        check("oneshot_idle_ready", 32'(cfg_ready), 1);

        // One-shot 200..250 step 20: last step clips at 250, no wrap.
        do_cfg(8'd200, 8'd250, 8'd20, 8'd2, 2'b00);
        push(0, 8'd200, -1); push(0, 8'd220, 2); push(0, 8'd240, 2); push(0, 8'd250, 2); push(1, 8'd0, 2);
        do_start();
        tick(4);
        // Config offered mid-sweep must be refused and ignored.
        @(negedge clk);
        cfg_valid = 1'b1; cfg_start = 8'd99; cfg_stop = 8'd99; cfg_step = 8'd1;
        check("busy_cfg_ready", 32'(cfg_ready), 0);
        tick(3);
        cfg_valid = 1'b0;
        wait_drain("clip_drain", 300);
        // Relaunch with the same shadow config proves the mid-sweep offer was not sampled.
        push(0, 8'd200, -1); push(0, 8'd220, 2); push(0, 8'd240, 2); push(0, 8'd250, 2); push(1, 8'd0, 2);
        do_start();
        wait_drain("shadow_kept_drain", 300);
        tick(2);
        check("clip_done_count", 32'(done_seen), 3);

        // Triangle 50..30 step 10, dwell 1, then abort.
        do_cfg(8'd50, 8'd30, 8'd10, 8'd1, 2'b10);
        push(0, 8'd50, -1); push(0, 8'd40, 1); push(0, 8'd30, 1);
        push(0, 8'd40, 1);  push(0, 8'd50, 1); push(0, 8'd40, 1);
        do_start();
        wait_drain("triangle_drain", 300);
        ld_mark   = ld_seen;
        done_mark = done_seen;
        do_abort();
        check("abort_busy", 32'(busy), 0);
        check("abort_ld", 32'(ld), 0);
        tick(20);
        check("abort_no_ld", 32'(ld_seen), 32'(ld_mark));
        check("abort_no_done", 32'(done_seen), 32'(done_mark));

        // Repeat 7..7 with step 0 (treated as 1), dwell 1.
        do_cfg(8'd7, 8'd7, 8'd0, 8'd1, 2'b01);
        push(0, 8'd7, -1); push(0, 8'd7, 1); push(0, 8'd7, 1); push(0, 8'd7, 1);
        do_start();
        wait_drain("repeat_drain", 200);
        ld_mark = ld_seen;
        do_abort();
        check("repeat_abort_busy", 32'(busy), 0);
        tick(20);
        check("repeat_abort_no_ld", 32'(ld_seen), 32'(ld_mark));
        check("repeat_par_load_kept", 32'(par_load), 7);

        // Reset in the middle of a dwell.
        do_cfg(8'd10, 8'd40, 8'd10, 8'd2, 2'b00);
        push(0, 8'd10, -1);
        do_start();
        wait_drain("rst_pre_drain", 50);
        tick(3);
        check("dwell_busy", 32'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_ld", 32'(ld), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_cfg_ready", 32'(cfg_ready), 1);
        check("midrst_par_load", 32'(par_load), 0);
        rst = 1'b0;
        exp_q.delete();
        ld_mark = ld_seen;
        do_start();
        tick(20);
        check("midrst_cfg_cleared", 32'(ld_seen), 32'(ld_mark));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/divider_sweep_ctrl.md
# divider_sweep_ctrl

Sweep controller that sequences the function generator's programmable clock divider. It steps the divider load value from a start setting to a stop setting in fixed increments and holds each setting for a programmed number of divided-clock periods. It supports one-shot, repeat and triangle (ping-pong) sweeps. It sits between the control/config logic and the divider's `par_load`/`ld` inputs, and observes the divider's `clk_div` output to time each dwell.

## Interface
- `WIDTH`, default 8: width of the divider load value.
- `DWELL_W`, default 8: width of the dwell count (divided-clock rising edges per step).

Ports:
- `clk` in 1: system clock. The divider runs on the same clock.
- `rst` in 1: reset, synchronous, active-high. Clock is `clk`.
- `cfg_valid` in 1: config offer.
- `cfg_ready` out 1: config accepted when `cfg_valid && cfg_ready`.
- `cfg_start` in WIDTH: first load value.
- `cfg_stop` in WIDTH: final load value.
- `cfg_step` in WIDTH: increment magnitude. 0 is treated as 1.
- `cfg_dwell` in DWELL_W: `clk_div` rising edges per step. 0 is treated as 1.
- `cfg_mode` in 2: 00 one-shot, 01 repeat, 10 triangle, 11 is treated as 00.
- `start` in 1: single-cycle sweep start.
- `abort` in 1: stop the sweep immediately.
- `clk_div` in 1: divider output, synchronous to `clk`.
- `par_load` out WIDTH: load value to the divider.
- `ld` out 1: one-cycle load strobe to the divider.
- `busy` out 1: sweep in progress.
- `done` out 1: one-cycle pulse at one-shot completion.

## Operation
- States: IDLE, LOAD, DWELL, STEP, DONE.
- Moore outputs:
  - `ld` = (state==LOAD).
  - `busy` = state in {LOAD, DWELL, STEP}.
  - `done` = (state==DONE).
  - `cfg_ready` = (state==IDLE).
- Config handshake:
  - A handshake in IDLE copies all `cfg_*` into shadow registers and sets `cfg_loaded`.
  - `cfg_*` values offered outside IDLE are never sampled.
- Direction:
  - `lo` = min(start, stop), `hi` = max(start, stop).
  - `dir` = up if start ≤ stop, else down.
  - `cur` is set to start on sweep launch.
- IDLE:
  - `start` with `cfg_loaded` goes to LOAD.
  - `start` without `cfg_loaded` is ignored.
- LOAD:
  - `par_load` ← `cur`, `ld` = 1 for exactly one cycle.
  - Dwell counter ← `cfg_dwell` (0 is treated as 1).
  - Next state is DWELL.
- DWELL:
  - A `clk_div` rising edge is detected from a registered previous sample.
  - Each detected edge decrements the dwell counter.
  - The edge that takes the counter from 1 to 0 moves the FSM to STEP.
- STEP, computed in WIDTH+1 bits with no wrap-around:
  - If `cur` ≠ end of the current leg: `cur` ← `cur` ± `step`, clipped to the end, then go to LOAD.
  - If `cur` == end and mode is one-shot: go to DONE.
  - If `cur` == end and mode is repeat: `cur` ← start, then go to LOAD.
  - If `cur` == end and mode is triangle: flip `dir`, `cur` ← `cur` ∓ `step` clipped to the opposite end, then go to LOAD. Endpoints are not repeated.
  - If start == stop: one-shot goes to DONE after one dwell; repeat and triangle reload `cur` every dwell.
- DONE:
  - `done` pulses for one cycle, then go to IDLE.
- `abort`:
  - From any state, go to IDLE at the next edge.
  - No `ld` or `done` is produced.
  - `par_load` keeps its last value.
  - `cfg_loaded` is kept.
- Priority: `rst` > `abort` > `start`/`cfg` > sweep progress.

## Timing
- Reset values:
  - State IDLE, `cfg_loaded` 0.
  - `par_load` 0, `ld` 0, `busy` 0, `done` 0, `cfg_ready` 1.
  - `cur` 0, `dir` up, previous `clk_div` sample 0.
- Reset mid-sweep: all of the above apply at the next edge.
- `start` sampled at edge N gives `ld`=1 and a valid `par_load` during cycle N+1.
- `clk_div` rising edge:
  - It is visible as a detected edge one cycle after it appears at the input.
  - The final dwell edge detected at edge E gives STEP in cycle E+1 and the next `ld` in cycle E+2.
- `par_load` changes only on entry to LOAD and is stable while `ld`=1.
- Consecutive `ld` pulses are at least 3 cycles apart.
- A `clk_div` edge during LOAD or STEP is not counted toward the dwell.

## Structure
- Package `sweep_pkg`:
  - State enum.
  - Mode constants `MODE_ONESHOT`, `MODE_REPEAT`, `MODE_TRIANGLE`.
- Sub-module `sweep_next` (combinational) takes `cur`, `step`, `lo`, `hi`, `dir` and `mode`. It returns `next`, `at_end` and `dir_next` using WIDTH+1-bit clipped arithmetic.
- The top level holds the FSM, the shadow config registers, the dwell counter and the edge detector.

## Test plan
- Reset, then idle 5 cycles: all outputs at their reset values, `cfg_ready`=1. `start` without config gives no `ld`.
- Config 10/40/10, dwell 2, one-shot, then `start`:
  - `ld` pulses with `par_load` 10, 20, 30, 40.
  - Each pulse follows 2 `clk_div` rising edges.
  - `done` pulses once, 2 edges after the load of 40.
  - `busy` drops with `done`.
- Config 200/250/20, one-shot: loads 200, 220, 240, 250, then `done`. No overflow to a value below 200.
- Config 50/30/10, triangle, dwell 1:
  - Loads 50, 40, 30, 40, 50, 40.
  - `abort` then gives `busy`=0 next cycle, with no `ld` and no `done`.
- Config 7/7/x, repeat, dwell 1: `ld` with `par_load`=7 once per `clk_div` period until `abort`.
- During a sweep, `cfg_valid` with 99/99/1: `cfg_ready`=0 and the running sweep is unchanged. Also, `rst` asserted mid-DWELL restores all reset values at the next edge.
